// File: rtl/alu_res_pkg.sv
// alu_res_pkg: shared definitions for the ALU result stage.
//   - flag bit indices inside the 5-bit flags vector
//   - entry_t: one buffered result {y, flags, err} (14 bits)
//   - skid buffer occupancy states
//   - flag_err(): consistency check applied when a result is captured
package alu_res_pkg;

  localparam int PARITY    = 4;
  localparam int OVERFLOW  = 3;
  localparam int GREATER   = 2;
  localparam int LESS      = 1;
  localparam int IS_EQ     = 0;

  localparam int CNT_W_DEF = 16;

  typedef struct packed {
    logic [7:0] y;
    logic [4:0] flags;
    logic       err;
  } entry_t;

  localparam int ENTRY_W = $bits(entry_t);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } skid_state_e;

  // A result is inconsistent when the parity flag disagrees with y, or when
  // the compare outcome is not exactly one of greater/less/equal.
  function automatic logic flag_err(input logic [7:0] y, input logic [4:0] flags);
    logic [1:0] ncmp;
    ncmp = {1'b0, flags[GREATER]} + {1'b0, flags[LESS]} + {1'b0, flags[IS_EQ]};
    return (flags[PARITY] != ^y) || (ncmp != 2'd1);
  endfunction

endpackage

// File: rtl/alu_res_skid.sv
// alu_res_skid: generic 2-entry skid buffer (main + skid register).
//   clk, rst            : clock, synchronous active-high reset
//   in_valid/in_ready   : upstream handshake; in_ready is a flop (= skid empty)
//   in_data[W]          : entry captured on input transfer
//   out_valid/out_ready : downstream handshake; out_valid is a flop
//   out_data[W]         : main register, stable while stalled
// Latency is one edge from input transfer to out_valid.
module alu_res_skid
  import alu_res_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  skid_state_e state, state_nx;
  logic [W-1:0] main_q, skid_q;
  logic         rdy_q, vld_q;
  logic         in_xfer, out_xfer;
  logic         load_main, load_skid, main_from_skid;

  assign in_ready  = rdy_q;
  assign out_valid = vld_q;
  assign out_data  = main_q;

  assign in_xfer  = in_valid && rdy_q;
  assign out_xfer = vld_q && out_ready;

  always_comb begin
    state_nx       = state;
    load_main      = 1'b0;
    load_skid      = 1'b0;
    main_from_skid = 1'b0;
    case (state)
      ST_EMPTY: begin
        if (in_xfer) begin
          state_nx  = ST_ONE;
          load_main = 1'b1;
        end
      end
      ST_ONE: begin
        case ({in_xfer, out_xfer})
          2'b10: begin
            // downstream stalled: park the new entry behind main
            state_nx  = ST_TWO;
            load_skid = 1'b1;
          end
          2'b01:   state_nx  = ST_EMPTY;
          2'b11:   load_main = 1'b1;
          default: ;
        endcase
      end
      ST_TWO: begin
        // in_ready is low here, so only the output side can move
        if (out_xfer) begin
          state_nx       = ST_ONE;
          load_main      = 1'b1;
          main_from_skid = 1'b1;
        end
      end
      default: state_nx = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_EMPTY;
      main_q <= '0;
      skid_q <= '0;
      rdy_q  <= 1'b1;
      vld_q  <= 1'b0;
    end else begin
      state <= state_nx;
      // handshake flags are registered copies of the next occupancy
      rdy_q <= (state_nx != ST_TWO);
      vld_q <= (state_nx != ST_EMPTY);
      if (load_main) main_q <= main_from_skid ? skid_q : in_data;
      if (load_skid) skid_q <= in_data;
    end
  end

endmodule

// File: rtl/alu_result_stage.sv
// alu_result_stage: registered output stage for ALU results.
//   clk, rst            : clock, synchronous active-high reset
//   in_valid/in_ready   : upstream handshake (in_ready registered)
//   in_y, in_flags      : ALU result and {parity,overflow,greater,less,is_eq}
//   out_valid/out_ready : downstream handshake
//   out_y, out_flags    : buffered result
//   out_err             : consistency error stored with the entry on out_*
//   sticky_ovf          : set by any accepted overflow result; clr_sticky clears
//   result_cnt          : number of accepted results, wraps mod 2^CNT_W
module alu_result_stage
  import alu_res_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_y,
  input  logic [4:0]       in_flags,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_y,
  output logic [4:0]       out_flags,
  output logic             out_err,
  output logic             sticky_ovf,
  input  logic             clr_sticky,
  output logic [CNT_W-1:0] result_cnt
);

  entry_t in_e, out_e;
  logic   in_xfer;

  // err is evaluated once at capture so it travels with the entry
  assign in_e.y     = in_y;
  assign in_e.flags = in_flags;
  assign in_e.err   = flag_err(in_y, in_flags);

  assign in_xfer = in_valid && in_ready;

  alu_res_skid #(.W(ENTRY_W)) u_skid (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_e),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_e)
  );

  assign out_y     = out_e.y;
  assign out_flags = out_e.flags;
  assign out_err   = out_e.err;

  always_ff @(posedge clk) begin
    if (rst) begin
      sticky_ovf <= 1'b0;
      result_cnt <= '0;
    end else begin
      // set has priority over clear
      if (in_xfer && in_flags[OVERFLOW]) sticky_ovf <= 1'b1;
      else if (clr_sticky)               sticky_ovf <= 1'b0;
      if (in_xfer) result_cnt <= result_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_alu_result_stage.sv
// tb_alu_result_stage: directed vectors with hand-computed expectations.
// Inputs change #1 after a rising edge; outputs are checked #1 after the
// following rising edge.
module tb_alu_result_stage;

  logic        clk = 1'b0;
  logic        rst, in_valid, out_ready, clr_sticky;
  logic [7:0]  in_y;
  logic [4:0]  in_flags;
  logic        in_ready, out_valid, out_err, sticky_ovf;
  logic [7:0]  out_y;
  logic [4:0]  out_flags;
  logic [15:0] result_cnt;
  logic        in_ready4, out_valid4, out_err4, sticky_ovf4;
  logic [7:0]  out_y4;
  logic [4:0]  out_flags4;
  logic [3:0]  result_cnt4;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  alu_result_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_y(in_y), .in_flags(in_flags), .out_valid(out_valid),
    .out_ready(out_ready), .out_y(out_y), .out_flags(out_flags),
    .out_err(out_err), .sticky_ovf(sticky_ovf), .clr_sticky(clr_sticky),
    .result_cnt(result_cnt)
  );

  // narrow counter copy sharing the same stimulus, for the wrap check
  alu_result_stage #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4),
    .in_y(in_y), .in_flags(in_flags), .out_valid(out_valid4),
    .out_ready(out_ready), .out_y(out_y4), .out_flags(out_flags4),
    .out_err(out_err4), .sticky_ovf(sticky_ovf4), .clr_sticky(clr_sticky),
    .result_cnt(result_cnt4)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [7:0] y, input logic [4:0] f);
    in_valid = v;
    in_y     = y;
    in_flags = f;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; clr_sticky = 1'b0;
    in_y = 8'hEE; in_flags = 5'b11111;
    #1;
    tick(); tick();
    rst = 1'b0;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    chk("rst_out_y",     32'(out_y),     32'd0);
    chk("rst_out_flags", 32'(out_flags), 32'd0);
    chk("rst_out_err",   32'(out_err),   32'd0);
    chk("rst_sticky",    32'(sticky_ovf),32'd0);
    chk("rst_cnt",       32'(result_cnt),32'd0);

    // single pass, first edge after reset release
    out_ready = 1'b1;
    drive(1'b1, 8'h5A, 5'b00001);
    tick();
    drive(1'b0, 8'hC3, 5'b11111);   // ignored: no transfer
    chk("pass_valid", 32'(out_valid), 32'd1);
    chk("pass_y",     32'(out_y),     32'h5A);
    chk("pass_flags", 32'(out_flags), 32'h01);
    chk("pass_err",   32'(out_err),   32'd0);
    chk("pass_cnt",   32'(result_cnt),32'd1);
    tick();
    chk("pass_drain", 32'(out_valid), 32'd0);
    chk("pass_cnt_hold", 32'(result_cnt), 32'd1);

    // backpressure: fill both entries, hold a third
    out_ready = 1'b0;
    drive(1'b1, 8'h01, 5'b10001);
    tick();
    chk("bp1_ready", 32'(in_ready), 32'd1);
    chk("bp1_y",     32'(out_y),    32'h01);
    drive(1'b1, 8'h02, 5'b10001);
    tick();
    chk("bp2_ready", 32'(in_ready), 32'd0);
    chk("bp2_y",     32'(out_y),    32'h01);
    drive(1'b1, 8'h03, 5'b00001);
    tick();
    chk("bp3_ready", 32'(in_ready), 32'd0);
    chk("bp3_y_hold",32'(out_y),    32'h01);
    chk("bp3_cnt",   32'(result_cnt),32'd3);
    out_ready = 1'b1;
    tick();                         // skid -> main, third still waiting
    chk("bp4_y",     32'(out_y),    32'h02);
    chk("bp4_ready", 32'(in_ready), 32'd1);
    chk("bp4_cnt",   32'(result_cnt),32'd3);
    tick();                         // third accepted while second leaves
    drive(1'b0, 8'h00, 5'b00000);
    chk("bp5_y",     32'(out_y),    32'h03);
    chk("bp5_valid", 32'(out_valid),32'd1);
    chk("bp5_cnt",   32'(result_cnt),32'd4);
    tick();
    chk("bp6_drain", 32'(out_valid),32'd0);

    // streaming at one per cycle
    for (int i = 0; i < 10; i++) begin
      logic [7:0] y;
      y = 8'(i);
      drive(1'b1, y, {^y, 4'b0001});
      tick();
      chk("st_ready", 32'(in_ready), 32'd1);
      chk("st_valid", 32'(out_valid),32'd1);
      chk("st_y",     32'(out_y),    32'(i));
      chk("st_err",   32'(out_err),  32'd0);
    end
    drive(1'b0, 8'h00, 5'b00000);
    tick();
    chk("st_cnt", 32'(result_cnt), 32'd14);

    // error detection
    drive(1'b1, 8'h07, 5'b00001);   // parity should be 1
    tick();
    chk("err_par_y",  32'(out_y),   32'h07);
    chk("err_par",    32'(out_err), 32'd1);
    drive(1'b1, 8'h03, 5'b00110);   // parity ok, greater and less both set
    tick();
    chk("err_cmp_y",  32'(out_y),   32'h03);
    chk("err_cmp",    32'(out_err), 32'd1);
    chk("err_sticky", 32'(sticky_ovf), 32'd0);

    // sticky: set beats simultaneous clear
    drive(1'b1, 8'h00, 5'b01001);
    clr_sticky = 1'b1;
    tick();
    chk("stk_set",  32'(sticky_ovf), 32'd1);
    chk("stk_err",  32'(out_err),    32'd0);
    chk("cnt17",    32'(result_cnt), 32'd17);
    chk("cnt4_wrap",32'(result_cnt4),32'd1);
    drive(1'b0, 8'hFF, 5'b01000);   // overflow without transfer: ignored
    tick();
    chk("stk_clr",  32'(sticky_ovf), 32'd0);
    clr_sticky = 1'b0;
    chk("stk_drain",32'(out_valid),  32'd0);

    // reset while TWO, with active handshakes in the reset cycle
    out_ready = 1'b0;
    drive(1'b1, 8'h11, 5'b00001);
    tick();
    drive(1'b1, 8'h22, 5'b00001);
    tick();
    chk("two_ready", 32'(in_ready), 32'd0);
    rst = 1'b1;
    out_ready = 1'b1;
    drive(1'b1, 8'h33, 5'b01001);
    tick();
    rst = 1'b0;
    chk("mrst_valid", 32'(out_valid), 32'd0);
    chk("mrst_ready", 32'(in_ready),  32'd1);
    chk("mrst_cnt",   32'(result_cnt),32'd0);
    chk("mrst_y",     32'(out_y),     32'd0);
    chk("mrst_sticky",32'(sticky_ovf),32'd0);
    // input still presented: accepted on the first edge after release
    drive(1'b1, 8'h5A, 5'b00001);
    tick();
    drive(1'b0, 8'h00, 5'b00000);
    chk("post_valid", 32'(out_valid), 32'd1);
    chk("post_y",     32'(out_y),     32'h5A);
    chk("post_cnt",   32'(result_cnt),32'd1);
    tick();
    chk("post_drain", 32'(out_valid), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/alu_result_stage.md
ALU_RESULT_STAGE -- requirements
Module: alu_result_stage

Interface
REQ-001 SHALL have one clock and one reset: reset is synchronous and active-high; ports named clk and rst.
REQ-002 Parameter CNT_W, default 16, width of the result counter.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 in_valid  input  1  upstream ALU result present.
REQ-006 in_ready  output  1  stage can accept a result this cycle.
REQ-007 in_y  input  8  ALU result y[7:0].
REQ-008 in_flags  input  5  {parity, overflow, greater, less, is_eq} from the ALU.
REQ-009 out_valid  output  1  registered result available downstream.
REQ-010 out_ready  input  1  downstream accepts the result.
REQ-011 out_y  output  8  buffered result.
REQ-012 out_flags  output  5  buffered flags, same bit order as in_flags.
REQ-013 out_err  output  1  consistency error for the result currently on out_*.
REQ-014 sticky_ovf  output  1  set by any accepted result with overflow=1.
REQ-015 clr_sticky  input  1  clears sticky_ovf.
REQ-016 result_cnt  output  CNT_W  count of results accepted at the input.

Function
REQ-017 Input transfer SHALL occur when in_valid && in_ready; output transfer SHALL occur when out_valid && out_ready.
REQ-018 Stage SHALL be a 2-entry skid buffer: main register plus skid register; latency 1 cycle from input transfer to out_valid.
REQ-019 in_ready SHALL be registered and equal to "skid register empty"; it SHALL NOT depend combinationally on out_ready.
REQ-020 States: EMPTY (0 entries), ONE (main full), TWO (main and skid full).
REQ-021 EMPTY: input transfer -> ONE.
REQ-022 ONE: input only -> TWO; output only -> EMPTY; both -> ONE with main loaded from input; neither -> ONE.
REQ-023 TWO: in_ready=0; output transfer -> ONE with skid moved into main the same edge.
REQ-024 Ordering SHALL be strict FIFO; no result dropped or duplicated, including output stall while TWO.
REQ-025 out_y/out_flags SHALL hold stable while out_valid && !out_ready.
REQ-026 out_err SHALL be computed at input capture and stored with the entry: err = (parity != ^y) OR (number of set bits among greater/less/is_eq != 1).
REQ-027 sticky_ovf SHALL set on input transfer with overflow=1; clr_sticky clears it; simultaneous set and clear -> set wins.
REQ-028 result_cnt SHALL increment by 1 per input transfer and wrap modulo 2^CNT_W.
REQ-029 Data on in_* when no input transfer occurs SHALL be ignored.

Reset
REQ-030 On rst=1 at a clock edge: state EMPTY, out_valid=0, in_ready=1, out_y=0, out_flags=0, out_err=0, sticky_ovf=0, result_cnt=0.
REQ-031 Reset mid-operation SHALL discard both buffered entries; handshakes asserted in the reset cycle SHALL have no effect.
REQ-032 First input transfer SHALL be possible on the first edge after rst deasserts.

Structure
REQ-033 Shared package alu_res_pkg SHALL hold the flag bit-index constants (PARITY=4, OVERFLOW=3, GREATER=2, LESS=1, IS_EQ=0), the 14-bit entry typedef {y, flags, err}, and the default CNT_W.
REQ-034 Skid buffer SHALL be one generic sub-module alu_res_skid, parameterised on entry width; checker, sticky and counter logic SHALL live in alu_result_stage.

Verification
REQ-035 Single pass: y=0x5A, flags=5'b0_0_0_0_1, out_ready=1 -> next cycle out_valid=1, out_y=0x5A, out_err=0, result_cnt=1.
REQ-036 Backpressure: out_ready=0, push 0x01,0x02 -> in_ready=0 after second; third push held; release out_ready -> outputs 0x01,0x02,0x03 in order, none lost.
REQ-037 Simultaneous in/out in ONE for 10 cycles with streaming y=0..9 -> throughput 1/cycle, in_ready stays 1, outputs 0..9.
REQ-038 Error check: y=0x07, parity=0 -> out_err=1; y=0x03, parity=0, greater=1 and less=1 -> out_err=1.
REQ-039 Sticky: overflow=1 result with clr_sticky=1 the same cycle -> sticky_ovf=1; clr_sticky next cycle -> 0.
REQ-040 Reset in TWO with out_ready=0 -> next cycle out_valid=0, in_ready=1, result_cnt=0; CNT_W=4, 17 pushes -> result_cnt=1.
